io_switch_led_responder: RTL and testbench
==========================================

// Module: io_switch_led_responder
// PURPOSE
//   Memory-mapped IO responder answering CPU ioRead/ioWrite accesses in the IO region
//   (addr[31:10] == 22'h3FFFFF). Holds the 24-bit LED output register and presents
//   debounced 24-bit switch input. Also provides a read-to-clear "switch changed" status flag.
//   Sits beside the memory/IO mux: the CPU is the initiator and this block is the device end.
// PARAMETERS
//   DEBOUNCE_CYCLES  50000  clock cycles between switch samples (>=2)
//   CNT_W            16     width of sample-tick counter; 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//   clock      in   1   CPU clock, all state on rising edge
//   reset      in   1   synchronous, active-high
//   ioRead     in   1   CPU IO read strobe, one cycle per load
//   ioWrite    in   1   CPU IO write strobe, one cycle per store
//   addr       in   32  byte address of the access
//   wdata      in   16  write data (low half of rt)
//   io_rdata   out  16  read data, combinational from current registers
//   switch_raw in   24  asynchronous board switches
//   LED        out  24  LED drive, registered
//   sw_changed out  1   status flag (mirror of STATUS bit0)
// BEHAVIOUR
//   Register map (only in IO region; other addresses are ignored, io_rdata=0):
//     FFFFFC60 LED_LO  RW  LED[15:0]
//     FFFFFC62 LED_HI  RW  LED[23:16] = wdata[7:0]; reads {8'h00,LED[23:16]}
//     FFFFFC70 SW_LO   RO  debounced sw[15:0]
//     FFFFFC72 SW_HI   RO  {8'h00, sw[23:16]}
//     FFFFFC74 STATUS  RO  {15'h0, pending}; read clears pending
//     Writes to RO or unmapped IO addresses: no effect. Reads of unmapped: 16'h0000.
//   Reset: LED=0, debounced sw=0, sync FFs=0, sample history=0, tick counter=0,
//     pending=0, io_rdata=0 (since sw=0 and LED=0). Reset mid-debounce discards history.
//   Write: LED register updates on the edge where ioWrite=1; visible on LED next cycle.
//     ioRead and ioWrite both high: the write takes effect and the read returns pre-edge value.
//   Read: io_rdata is valid in the same cycle as ioRead (single-cycle CPU latency 0);
//     io_rdata is a pure function of addr and current registers, ioRead does not gate it.
//     Pending is cleared on the edge where ioRead=1 and addr==FFFFFC74.
//   Sync: switch_raw passes through a 2-FF synchronizer before sampling.
//   Tick: counter counts 0..DEBOUNCE_CYCLES-1 then wraps to 0; tick=1 on the cycle
//     counter==DEBOUNCE_CYCLES-1. Free-running, unaffected by bus traffic.
//   Debounce: on tick each bit shifts synced value into a 3-deep history h[2:0].
//     A bit of sw updates to the new value when h (after the shift) is all-0 or all-1 and
//     differs from the current sw bit. Minimum latency from a raw change to sw = 2 sync +
//     3 ticks (up to 3*DEBOUNCE_CYCLES+2 cycles). Glitches shorter than 3 ticks never reach sw.
//   Pending: set on any edge where >=1 sw bit changes. If set and clear coincide, set
//     wins (pending stays 1), so no change event is lost.
//   sw_changed == pending at all times.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   Reset: assert reset 2 cycles -> LED=0, sw_changed=0, read FFFFFC70 gives 0000, FFFFFC74 gives 0000.
//   LED write: ioWrite addr FFFFFC60 wdata A5C3, then FFFFFC62 wdata 1234 -> LED=24'h34A5C3;
//     read FFFFFC62 -> 0034.
//   Debounce: switch_raw=24'h00F00F held -> SW_LO=F00F and SW_HI=0000 appear within 14 cycles,
//     then sw_changed=1. A 1-tick pulse on bit 23 never changes SW_HI.
//   Read-to-clear: pending=1, ioRead FFFFFC74 -> io_rdata=0001 and pending=0 next cycle;
//     if a new sw change lands on the same edge, pending stays 1.
//   Decode: ioWrite to FFFFFC70 or to 0000FC60 -> LED unchanged; read FFFFFC80 -> 0000.
//   Reset mid-op: reset during a debounce in progress -> sw=0, history cleared, a later
//     stable input again needs the full 3 ticks.

Source files
------------

// File: rtl/io_switch_led_responder.sv
// Memory-mapped IO responder: LED output register, debounced switch inputs and a
// read-to-clear "switch changed" status flag, all decoded from the CPU IO region.
module io_switch_led_responder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioRead,
    input  logic        ioWrite,
    input  logic [31:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] io_rdata,
    input  logic [23:0] switch_raw,
    output logic [23:0] LED,
    output logic        sw_changed
);

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [21:0]      IO_REGION  = 22'h3FFFFF;
    localparam logic [9:0]       OFF_LED_LO = 10'h060;
    localparam logic [9:0]       OFF_LED_HI = 10'h062;
    localparam logic [9:0]       OFF_SW_LO  = 10'h070;
    localparam logic [9:0]       OFF_SW_HI  = 10'h072;
    localparam logic [9:0]       OFF_STATUS = 10'h074;

    logic [23:0]      sync_1;
    logic [23:0]      sync_2;
    logic [23:0]      hist_0;
    logic [23:0]      hist_1;
    logic [23:0]      hist_2;
    logic [23:0]      sw;
    logic [CNT_W-1:0] tick_cnt;
    logic             pending;

    logic        in_io;
    logic        sel_led_lo;
    logic        sel_led_hi;
    logic        sel_sw_lo;
    logic        sel_sw_hi;
    logic        sel_status;
    logic        tick;
    logic [23:0] all_one;
    logic [23:0] all_zero;
    logic [23:0] sw_next;
    logic        sw_change;
    logic        status_clr;

    always_comb begin
        in_io      = (addr[31:10] == IO_REGION);
        sel_led_lo = in_io && (addr[9:0] == OFF_LED_LO);
        sel_led_hi = in_io && (addr[9:0] == OFF_LED_HI);
        sel_sw_lo  = in_io && (addr[9:0] == OFF_SW_LO);
        sel_sw_hi  = in_io && (addr[9:0] == OFF_SW_HI);
        sel_status = in_io && (addr[9:0] == OFF_STATUS);
    end

    // History is judged after this tick's shift: the incoming sample plus the two newest.
    always_comb begin
        tick       = (tick_cnt == TICK_LAST);
        all_one    = sync_2 & hist_0 & hist_1;
        all_zero   = ~(sync_2 | hist_0 | hist_1);
        sw_next    = tick ? ((sw & ~all_zero) | all_one) : sw;
        sw_change  = (sw_next != sw);
        status_clr = ioRead && sel_status;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1   <= '0;
            sync_2   <= '0;
            hist_0   <= '0;
            hist_1   <= '0;
            hist_2   <= '0;
            sw       <= '0;
            tick_cnt <= '0;
            pending  <= 1'b0;
            LED      <= '0;
        end else begin
            sync_1   <= switch_raw;
            sync_2   <= sync_1;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            if (tick) begin
                hist_0 <= sync_2;
                hist_1 <= hist_0;
                hist_2 <= hist_1;
            end
            sw <= sw_next;
            // A change landing on the clearing edge keeps the flag set.
            pending <= sw_change | (pending & ~status_clr);
            if (ioWrite && sel_led_lo) begin
                LED[15:0] <= wdata;
            end
            if (ioWrite && sel_led_hi) begin
                LED[23:16] <= wdata[7:0];
            end
        end
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (sel_led_lo) begin
            io_rdata = LED[15:0];
        end else if (sel_led_hi) begin
            io_rdata = {8'h00, LED[23:16]};
        end else if (sel_sw_lo) begin
            io_rdata = sw[15:0];
        end else if (sel_sw_hi) begin
            io_rdata = {8'h00, sw[23:16]};
        end else if (sel_status) begin
            io_rdata = {15'h0000, pending};
        end
    end

    assign sw_changed = pending;

endmodule

// File: tb/tb_io_switch_led_responder.sv
// Self-checking bench for io_switch_led_responder: directed register-map and debounce
// scenarios followed by randomized bus traffic, all against a behavioural model.
module tb_io_switch_led_responder;

    localparam int D = 4;

    logic        clock;
    logic        reset;
    logic        ioRead;
    logic        ioWrite;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] io_rdata;
    logic [23:0] switch_raw;
    logic [23:0] LED;
    logic        sw_changed;

    io_switch_led_responder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ioRead    (ioRead),
        .ioWrite   (ioWrite),
        .addr      (addr),
        .wdata     (wdata),
        .io_rdata  (io_rdata),
        .switch_raw(switch_raw),
        .LED       (LED),
        .sw_changed(sw_changed)
    );

    // clock/reset block
    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // behavioural model state
    logic [23:0] m_led;
    logic [23:0] m_sw;
    logic        m_pending;
    logic [23:0] m_s1;
    logic [23:0] m_s2;
    logic [23:0] m_h[3];
    int          m_cnt;

    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] addr_tab[8] = '{32'hFFFFFC60, 32'hFFFFFC62, 32'hFFFFFC70, 32'hFFFFFC72,
                                 32'hFFFFFC74, 32'hFFFFFC80, 32'h0000FC60, 32'hFFFFFC61};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // A bit settles to a value once the last three samples all agree on it.
    function automatic logic [23:0] debounce_rule(input logic [23:0] a, input logic [23:0] b,
                                                  input logic [23:0] c, input logic [23:0] cur);
        logic [23:0] r;
        for (int i = 0; i < 24; i++) begin
            r[i] = (a[i] == b[i] && b[i] == c[i]) ? a[i] : cur[i];
        end
        return r;
    endfunction

    function automatic logic [15:0] model_rdata(input logic [31:0] a);
        case (a)
            32'hFFFFFC60: return m_led[15:0];
            32'hFFFFFC62: return {8'h00, m_led[23:16]};
            32'hFFFFFC70: return m_sw[15:0];
            32'hFFFFFC72: return {8'h00, m_sw[23:16]};
            32'hFFFFFC74: return {15'h0000, m_pending};
            default:      return 16'h0000;
        endcase
    endfunction

    function automatic bit model_next_change();
        return (m_cnt == D - 1) && (debounce_rule(m_s2, m_h[0], m_h[1], m_sw) != m_sw);
    endfunction

    task automatic model_step();
        bit          tick;
        bit          clr;
        logic [23:0] new_sw;
        if (reset) begin
            m_led = '0; m_sw = '0; m_pending = 1'b0; m_s1 = '0; m_s2 = '0;
            m_h[0] = '0; m_h[1] = '0; m_h[2] = '0; m_cnt = 0;
            return;
        end
        tick   = (m_cnt == D - 1);
        m_cnt  = tick ? 0 : m_cnt + 1;
        new_sw = m_sw;
        if (tick) begin
            m_h[2] = m_h[1];
            m_h[1] = m_h[0];
            m_h[0] = m_s2;
            new_sw = debounce_rule(m_h[0], m_h[1], m_h[2], m_sw);
        end
        clr       = ioRead && (addr == 32'hFFFFFC74);
        m_pending = (new_sw != m_sw) || (m_pending && !clr);
        m_sw      = new_sw;
        if (ioWrite && addr == 32'hFFFFFC60) m_led[15:0] = wdata;
        if (ioWrite && addr == 32'hFFFFFC62) m_led[23:16] = wdata[7:0];
        m_s2 = m_s1;
        m_s1 = switch_raw;
    endtask

    // driver tasks: inputs change at the falling edge, outputs checked away from rising edge
    task automatic set_bus(input bit rd, input bit wr, input logic [31:0] a, input logic [15:0] d);
        ioRead  = rd;
        ioWrite = wr;
        addr    = a;
        wdata   = d;
    endtask

    task automatic tick_cycle();
        exp_q.push_back({16'h0000, model_rdata(addr)});
        #1;
        check("rdata", {16'h0000, io_rdata}, exp_q.pop_front());
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("led", {8'h00, LED}, {8'h00, m_led});
        check("sw_changed", {31'h0, sw_changed}, {31'h0, m_pending});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
        end
        reset = 1'b0;
        set_bus(0, 0, 32'h0, 16'h0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [15:0] d);
        set_bus(0, 1, a, d);
        tick_cycle();
        set_bus(0, 0, 32'h0, 16'h0);
    endtask

    task automatic do_read_expect(input string tag, input logic [31:0] a, input logic [15:0] exp);
        set_bus(1, 0, a, 16'h0);
        #1;
        check(tag, {16'h0000, io_rdata}, {16'h0000, exp});
        tick_cycle();
        set_bus(0, 0, 32'h0, 16'h0);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        check(tag, {16'h0000, io_rdata}, {16'h0000, exp});
    endtask

    initial begin
        bit found;
        int n;
        int op;
        switch_raw = '0;
        set_bus(0, 0, 32'h0, 16'h0);
        do_reset();

        check("reset_led", {8'h00, LED}, 32'h0);
        check("reset_sw_changed", {31'h0, sw_changed}, 32'h0);
        do_read_expect("reset_sw_lo", 32'hFFFFFC70, 16'h0000);
        do_read_expect("reset_status", 32'hFFFFFC74, 16'h0000);

        do_write(32'hFFFFFC60, 16'hA5C3);
        do_write(32'hFFFFFC62, 16'h1234);
        check("led_value", {8'h00, LED}, 32'h0034A5C3);
        do_read_expect("led_hi_read", 32'hFFFFFC62, 16'h0034);
        do_read_expect("led_lo_read", 32'hFFFFFC60, 16'hA5C3);

        switch_raw = 24'h00F00F;
        found = 0;
        for (int i = 0; i < 14 && !found; i++) begin
            tick_cycle();
            addr = 32'hFFFFFC70;
            #1;
            if (io_rdata == 16'hF00F) found = 1;
        end
        check("sw_lo_latency", {31'h0, found}, 32'h1);
        peek("sw_hi_after_debounce", 32'hFFFFFC72, 16'h0000);
        check("sw_changed_set", {31'h0, sw_changed}, 32'h1);

        // one-tick-wide pulse on bit 23 must be filtered out
        switch_raw = 24'h80F00F;
        repeat (D) tick_cycle();
        switch_raw = 24'h00F00F;
        repeat (20) tick_cycle();
        peek("sw_hi_glitch", 32'hFFFFFC72, 16'h0000);

        do_read_expect("status_pending", 32'hFFFFFC74, 16'h0001);
        check("status_cleared", {31'h0, sw_changed}, 32'h0);
        do_read_expect("status_reread", 32'hFFFFFC74, 16'h0000);

        switch_raw = 24'h00F0FF;
        for (int i = 0; i < 20 && !sw_changed; i++) tick_cycle();
        check("pend_rise", {31'h0, sw_changed}, 32'h1);
        switch_raw = 24'h00F0F0;
        found = 0;
        for (int i = 0; i < 24 && !found; i++) begin
            if (model_next_change()) found = 1;
            else tick_cycle();
        end
        check("collide_found", {31'h0, found}, 32'h1);
        do_read_expect("collide_read", 32'hFFFFFC74, 16'h0001);
        check("collide_set_wins", {31'h0, sw_changed}, 32'h1);
        do_read_expect("collide_reread", 32'hFFFFFC74, 16'h0001);
        check("collide_cleared", {31'h0, sw_changed}, 32'h0);

        do_write(32'hFFFFFC70, 16'hFFFF);
        do_write(32'h0000FC60, 16'hFFFF);
        do_write(32'hFFFFFC74, 16'hFFFF);
        check("decode_led_kept", {8'h00, LED}, 32'h0034A5C3);
        do_read_expect("unmapped_read", 32'hFFFFFC80, 16'h0000);
        do_read_expect("outside_region", 32'h0000FC70, 16'h0000);

        // reset in the middle of a debounce, then a full re-debounce
        switch_raw = 24'hABCDEF;
        repeat (9) tick_cycle();
        do_reset();
        peek("rst_sw_lo", 32'hFFFFFC70, 16'h0000);
        peek("rst_sw_hi", 32'hFFFFFC72, 16'h0000);
        check("rst_sw_changed", {31'h0, sw_changed}, 32'h0);
        n = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick_cycle();
            n++;
            addr = 32'hFFFFFC70;
            #1;
            if (io_rdata != 16'h0000) found = 1;
        end
        check("rst_relatch_cycles", n, 12);
        peek("rst_relatch_lo", 32'hFFFFFC70, 16'hCDEF);
        peek("rst_relatch_hi", 32'hFFFFFC72, 16'h00AB);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 23) == 0) switch_raw = 24'($urandom);
                op = int'($urandom_range(0, 3));
                set_bus((op & 1) != 0, (op & 2) != 0, addr_tab[$urandom_range(0, 7)],
                        16'($urandom));
                tick_cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
